// File: rtl/if_fetch_stage.sv
// if_fetch_stage: owns the PC, runs the req/ack handshake with instruction memory
// and presents the held instruction and PC+4 to the IF/ID register.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_plus4_o,
    output logic        valid_o,
    output logic        ifid_write_o
);
    typedef enum logic [1:0] {REQ, HOLD, DROP} state_t;
    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_fetch_addr;
    logic [31:0] r_instr;
    logic [31:0] r_pc_plus4;
    logic        r_valid;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= REQ;
            r_pc         <= RESET_PC;
            r_fetch_addr <= RESET_PC;
            r_instr      <= NOP_INSTR;
            r_pc_plus4   <= RESET_PC + 32'd4;
            r_valid      <= 1'b0;
        end else begin
            case (r_state)
                REQ: begin
                    // fetch_addr only moves on ack so the bus address stays stable
                    if (redirect_i) begin
                        r_pc <= redirect_pc_i;
                        if (imem_ack_i) r_fetch_addr <= redirect_pc_i;
                        else            r_state      <= DROP;
                    end else if (imem_ack_i) begin
                        r_instr    <= imem_rdata_i;
                        r_pc_plus4 <= r_pc + 32'd4;
                        r_valid    <= 1'b1;
                        r_state    <= HOLD;
                    end
                end
                HOLD: begin
                    if (redirect_i) begin
                        r_pc         <= redirect_pc_i;
                        r_fetch_addr <= redirect_pc_i;
                        r_instr      <= NOP_INSTR;
                        r_valid      <= 1'b0;
                        r_state      <= REQ;
                    end else if (!stall_i) begin
                        r_pc         <= r_pc + 32'd4;
                        r_fetch_addr <= r_pc + 32'd4;
                        r_valid      <= 1'b0;
                        r_state      <= REQ;
                    end
                end
                DROP: begin
                    if (redirect_i) begin
                        r_pc <= redirect_pc_i;
                    end else if (imem_ack_i) begin
                        r_fetch_addr <= r_pc;
                        r_state      <= REQ;
                    end
                end
                default: r_state <= REQ;
            endcase
        end
    end
    assign imem_req_o   = r_state != HOLD;
    assign imem_addr_o  = r_fetch_addr;
    assign instr_o      = r_valid ? r_instr : NOP_INSTR;
    assign pc_plus4_o   = r_pc_plus4;
    assign valid_o      = r_valid;
    assign ifid_write_o = ~stall_i;
endmodule
